// File: rtl/pmem_arbiter.sv
// Two-master arbiter sharing one line-granularity memory port between the I-cache and D-cache.
// One master owns the port from grant until mem_resp; at least one IDLE cycle separates transactions.
module pmem_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  typedef enum logic {GRANT_D, GRANT_I} master_t;

  state_t                state;
  state_t                next_state;
  master_t               last_grant;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_address;
  logic [LINE_WIDTH-1:0] lat_wdata;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Grants are only issued from IDLE, so the resp cycle can never re-grant on a stale request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req && d_req) begin
        if (ROUND_ROBIN && (last_grant == GRANT_D)) grant_i = 1'b1;
        else                                        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (grant_i)      next_state = I_BUSY;
        else if (grant_d) next_state = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command latch: frozen for the whole transaction, so requester changes cannot disturb memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= GRANT_D;
      lat_write   <= 1'b0;
      lat_address <= '0;
      lat_wdata   <= '0;
    end else if (grant_i) begin
      last_grant  <= GRANT_I;
      lat_write   <= 1'b0;
      lat_address <= i_pmem_address;
      lat_wdata   <= '0;
    end else if (grant_d) begin
      last_grant  <= GRANT_D;
      lat_write   <= d_pmem_write;
      lat_address <= d_pmem_address;
      lat_wdata   <= d_pmem_write ? d_pmem_wdata : '0;
    end
  end

  // Output logic; rdata and resp reach only the current owner.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    i_pmem_rdata = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    if (!rst) begin
      unique case (state)
        I_BUSY: begin
          mem_read     = 1'b1;
          mem_address  = lat_address;
          i_pmem_rdata = mem_rdata;
          i_pmem_resp  = mem_resp;
        end
        D_BUSY: begin
          mem_read     = ~lat_write;
          mem_write    = lat_write;
          mem_address  = lat_address;
          mem_wdata    = lat_write ? lat_wdata : '0;
          d_pmem_rdata = mem_rdata;
          d_pmem_resp  = mem_resp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a cycle table for single-master traffic plus hand sequences
// for arbitration (round-robin and fixed priority instances share stimulus) and mid-transaction reset.
module tb_pmem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam logic [LW-1:0] A5   = {32{8'hA5}};
  localparam logic [LW-1:0] W1   = {8{32'h1234_5678}};
  localparam logic [LW-1:0] W2   = {8{32'hCAFE_F00D}};
  localparam logic [LW-1:0] ONES = {LW{1'b1}};
  localparam logic [AW-1:0] AI   = 32'h0000_0100;
  localparam logic [AW-1:0] AD   = 32'h0000_0200;

  logic          clk;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  logic [LW-1:0] i_pmem_rdata, d_pmem_rdata, mem_wdata;
  logic          i_pmem_resp, d_pmem_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;

  logic [LW-1:0] b_i_pmem_rdata, b_d_pmem_rdata, b_mem_wdata;
  logic          b_i_pmem_resp, b_d_pmem_resp, b_mem_read, b_mem_write;
  logic [AW-1:0] b_mem_address;

  int total;
  int bad;

  pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ROUND_ROBIN(1'b0)) u_fixed (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(b_i_pmem_rdata), .i_pmem_resp(b_i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(b_d_pmem_rdata), .d_pmem_resp(b_d_pmem_resp),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          resp;
    logic          e_rd;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
    logic          e_i_resp;
    logic          e_d_resp;
    logic [LW-1:0] e_i_rdata;
    logic [LW-1:0] e_d_rdata;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    mem_resp       = 1'b0;
    mem_rdata      = A5;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();

    //          i_rd i_addr       d_rd d_wr d_addr        d_wdata resp  e_rd e_wr e_addr        e_wdata e_i_resp e_d_resp e_i_rdata e_d_rdata
    vecs[0]  = '{1'b1, 32'h0000_1040, 1'b0, 1'b0, 32'h0,        '0,   1'b0, 1'b0, 1'b0, 32'h0,        '0, 1'b0, 1'b0, '0, '0};
    vecs[1]  = '{1'b1, 32'h0000_1040, 1'b0, 1'b0, 32'h0,        '0,   1'b0, 1'b1, 1'b0, 32'h0000_1040, '0, 1'b0, 1'b0, A5, '0};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = vecs[1];
    vecs[5]  = '{1'b1, 32'h0000_1040, 1'b0, 1'b0, 32'h0,        '0,   1'b1, 1'b1, 1'b0, 32'h0000_1040, '0, 1'b1, 1'b0, A5, '0};
    // request dropped after resp; mem_resp while idle must be ignored
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        '0,   1'b1, 1'b0, 1'b0, 32'h0,        '0, 1'b0, 1'b0, '0, '0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        '0,   1'b0, 1'b0, 1'b0, 32'h0,        '0, 1'b0, 1'b0, '0, '0};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_2000, W1,   1'b0, 1'b0, 1'b0, 32'h0,        '0, 1'b0, 1'b0, '0, '0};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFF, ONES, 1'b0, 1'b0, 1'b1, 32'h0000_2000, W1, 1'b0, 1'b0, '0, A5};
    vecs[10] = vecs[9];
    vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFF, ONES, 1'b1, 1'b0, 1'b1, 32'h0000_2000, W1, 1'b0, 1'b1, '0, A5};
    vecs[12] = vecs[7];
    // read and write together count as a write
    vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_3000, W2,   1'b0, 1'b0, 1'b0, 32'h0,        '0, 1'b0, 1'b0, '0, '0};
    vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_3000, W2,   1'b0, 1'b0, 1'b1, 32'h0000_3000, W2, 1'b0, 1'b0, '0, A5};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_3000, W2,   1'b1, 1'b0, 1'b1, 32'h0000_3000, W2, 1'b0, 1'b1, '0, A5};
    vecs[16] = vecs[7];
    // D read: wdata must not leak onto the memory port
    vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_4000, W1,   1'b0, 1'b0, 1'b0, 32'h0,        '0, 1'b0, 1'b0, '0, '0};
    vecs[18] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_4000, W1,   1'b0, 1'b1, 1'b0, 32'h0000_4000, '0, 1'b0, 1'b0, '0, A5};
    vecs[19] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_4000, W1,   1'b1, 1'b1, 1'b0, 32'h0000_4000, '0, 1'b0, 1'b1, '0, A5};
    vecs[20] = vecs[7];

    // Reset state
    do_reset();
    #1;
    check("rst_mem_read",  mem_read,     '0);
    check("rst_mem_write", mem_write,    '0);
    check("rst_mem_addr",  mem_address,  '0);
    check("rst_i_rdata",   i_pmem_rdata, '0);
    check("rst_d_rdata",   d_pmem_rdata, '0);
    check("rst_resps",     {i_pmem_resp, d_pmem_resp}, '0);

    // Cycle table
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      i_pmem_read    = vecs[i].i_rd;
      i_pmem_address = vecs[i].i_addr;
      d_pmem_read    = vecs[i].d_rd;
      d_pmem_write   = vecs[i].d_wr;
      d_pmem_address = vecs[i].d_addr;
      d_pmem_wdata   = vecs[i].d_wdata;
      mem_resp       = vecs[i].resp;
      #1;
      check($sformatf("v%0d_mem_read", i),  mem_read,     vecs[i].e_rd);
      check($sformatf("v%0d_mem_write", i), mem_write,    vecs[i].e_wr);
      check($sformatf("v%0d_mem_addr", i),  mem_address,  vecs[i].e_addr);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata,    vecs[i].e_wdata);
      check($sformatf("v%0d_i_resp", i),    i_pmem_resp,  vecs[i].e_i_resp);
      check($sformatf("v%0d_d_resp", i),    d_pmem_resp,  vecs[i].e_d_resp);
      check($sformatf("v%0d_i_rdata", i),   i_pmem_rdata, vecs[i].e_i_rdata);
      check($sformatf("v%0d_d_rdata", i),   d_pmem_rdata, vecs[i].e_d_rdata);
    end

    // Both masters request continuously: round-robin alternates I,D,I; fixed priority always grants D
    do_reset();
    for (int r = 0; r < 3; r++) begin
      logic rr_i;
      rr_i = (r % 2 == 0);
      @(negedge clk);
      i_pmem_read    = 1'b1;
      i_pmem_address = AI;
      d_pmem_read    = 1'b1;
      d_pmem_address = AD;
      mem_resp       = 1'b0;
      #1;
      check($sformatf("arb%0d_turn_rr", r),    {mem_read, mem_write},     '0);
      check($sformatf("arb%0d_turn_fixed", r), {b_mem_read, b_mem_write}, '0);
      @(negedge clk);
      #1;
      check($sformatf("arb%0d_rr_addr", r),    mem_address,   rr_i ? AI : AD);
      check($sformatf("arb%0d_rr_read", r),    mem_read,      1'b1);
      check($sformatf("arb%0d_fixed_addr", r), b_mem_address, AD);
      check($sformatf("arb%0d_fixed_irsp", r), b_i_pmem_rdata, '0);
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      check($sformatf("arb%0d_rr_iresp", r),    i_pmem_resp,   rr_i);
      check($sformatf("arb%0d_rr_dresp", r),    d_pmem_resp,   !rr_i);
      check($sformatf("arb%0d_fixed_dresp", r), b_d_pmem_resp, 1'b1);
      check($sformatf("arb%0d_fixed_iresp", r), b_i_pmem_resp, 1'b0);
    end
    @(negedge clk);
    clear_inputs();

    // Reset during D_BUSY abandons the transaction
    do_reset();
    @(negedge clk);
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_5000;
    d_pmem_wdata   = W1;
    @(negedge clk);
    #1;
    check("mrst_busy_write", mem_write, 1'b1);
    @(negedge clk);
    rst          = 1'b1;
    d_pmem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_mem_write", mem_write,   '0);
    check("mrst_mem_addr",  mem_address, '0);
    check("mrst_mem_wdata", mem_wdata,   '0);
    check("mrst_d_rdata",   d_pmem_rdata, '0);
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    check("mrst_late_dresp", d_pmem_resp, 1'b0);
    check("mrst_late_cmd",   {mem_read, mem_write}, '0);
    @(negedge clk);
    mem_resp = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Two-master arbiter that shares the single physical-memory (cacheline adaptor) port between the pipelined I-cache and the D-cache.
- Accepts line-granularity read requests from the I-cache and read or write requests from the D-cache.
- Grants one requester at a time, latches its command, and holds it on the memory port until mem_resp.
- Routes the response back to the granted requester only.

Parameters:
- LINE_WIDTH, 256: cache line width in bits.
- ADDR_WIDTH, 32: physical address width.
- ROUND_ROBIN, 1: 1 alternates between masters on simultaneous requests; 0 gives the D-cache fixed priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_pmem_read  in  1  I-cache line read request
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  out  LINE_WIDTH  read line to I-cache
- i_pmem_resp  out  1  I-cache transaction complete
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache line writeback request
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache writeback line
- d_pmem_rdata  out  LINE_WIDTH  read line to D-cache
- d_pmem_resp  out  1  D-cache transaction complete
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data
- mem_resp  in  1  memory transaction complete

Behaviour:
- Reset (rst, synchronous, active-high; clock clk):
  - State goes to IDLE; last_grant register clears to D.
  - Latched address/data/op registers clear to 0.
  - All outputs are 0.
  - Reset asserted mid-transaction abandons the transaction. No resp is forwarded; the memory side must also be reset.
- States: IDLE, I_BUSY, D_BUSY.
- IDLE: evaluated at each clock edge.
  - Only the I-cache requesting: go to I_BUSY. Latch i_pmem_address and op=read.
  - Only the D-cache requesting: go to D_BUSY. Latch d_pmem_address, d_pmem_wdata, and op=write if d_pmem_write else read.
  - Both requesting, ROUND_ROBIN=1: grant the master not equal to last_grant.
  - Both requesting, ROUND_ROBIN=0: grant D.
  - last_grant updates on every grant.
- Latency: memory command asserts in the first cycle after the request is seen in IDLE (1-cycle registered grant).
- I_BUSY / D_BUSY outputs:
  - mem_read or mem_write per the latched op; mem_address and mem_wdata driven from the latched registers.
  - mem_wdata is 0 for reads.
  - The command holds steady regardless of requester input changes.
- Response routing:
  - On mem_resp, the owner's *_pmem_resp=1 combinationally in the same cycle; the other master's resp stays 0.
  - The next state is IDLE.
- Read data: *_pmem_rdata = mem_rdata for the owner during its busy state, else 0.
- Turnaround: after the resp cycle, at least one IDLE cycle occurs before any new command. A requester still asserting its request in the resp cycle is not re-granted on stale state.
- Requester drops its request while busy: the command is still held until mem_resp, because memory cannot abort. The resp pulse is still forwarded.
- d_pmem_read and d_pmem_write both high: treated as write.
- mem_resp while in IDLE: ignored; no resp is forwarded.
- The non-granted master waits indefinitely with its request held. It is never given a response early.
- Starvation bound with ROUND_ROBIN=1: any requester is granted within one other transaction.

Test Plan:
- Single I read:
  - Stimulus: i_pmem_read=1, addr 0x0000_1040; mem_resp after 5 cycles with rdata=0xA5…A5.
  - Required: mem_read=1 with mem_address 0x0000_1040 from cycle+1; i_pmem_resp=1 for 1 cycle with i_pmem_rdata=0xA5…A5; d_pmem_resp=0 throughout.
- D writeback:
  - Stimulus: d_pmem_write=1, addr 0x0000_2000, wdata=0x1234…; address/wdata changed to 0xFFFF_FFFF mid-transaction.
  - Required: mem_write=1, mem_address stays 0x0000_2000, mem_wdata stays the original value until mem_resp; then d_pmem_resp=1 for 1 cycle.
- Simultaneous requests after reset, ROUND_ROBIN=1:
  - Stimulus: both masters request together.
  - Required: I granted first (last_grant=D). D granted after the IDLE turnaround. Next simultaneous pair grants I.
- ROUND_ROBIN=0, repeated simultaneous requests:
  - Required: D granted every time while the D request persists; I waits with i_pmem_resp=0.
- Reset mid-transaction:
  - Stimulus: rst asserted for 1 cycle during D_BUSY.
  - Required: next cycle all outputs are 0 and state is IDLE; a later mem_resp is not forwarded.
- Stale request in the resp cycle:
  - Stimulus: I request held high through the resp cycle, then dropped.
  - Required: no second mem_read is issued.
